sysid_checker: RTL and testbench

- Avalon-MM read master that interrogates a system-ID slave once per request.
- Reads word 0 (ID) and word 1 (timestamp), then compares both against build-time expected values.
- Publishes the captured values and a match/mismatch verdict to boot/status logic, so the firmware and hardware build pairing is confirmed before LED tile traffic is enabled.

---
 rtl/sysid_checker_pkg.sv | 24 ++
 rtl/avm_single_read.sv | 66 ++++++
 rtl/sysid_checker.sv | 178 +++++++++++++++++
 tb/tb_sysid_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// slave word addresses and the 32-bit data word.
package sysid_checker_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    CHECK
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // True while a slave read is outstanding (strobe or latency phase).
  function automatic logic is_read_phase(input state_t s);
    return s inside {RD_ID, LAT_ID, RD_TS, LAT_TS};
  endfunction

endpackage

// File: rtl/avm_single_read.sv
// One Avalon-MM read handshake: drives the strobe while req_i is high and
// raises ack_o in the cycle the returned word is valid on data_o.
module avm_single_read
  import sysid_checker_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  req_i,
  input  logic  addr_i,
  input  logic  flush_i,
  output logic  accept_o,
  output logic  ack_o,
  output word_t data_o,
  output logic  avm_read_o,
  output logic  avm_address_o,
  input  logic  avm_waitrequest_i,
  input  word_t avm_readdata_i
);

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  logic       pend_q, pend_d;
  logic [1:0] cnt_q, cnt_d;

  assign avm_read_o    = req_i;
  assign avm_address_o = addr_i;
  assign accept_o      = req_i & ~avm_waitrequest_i;
  assign data_o        = avm_readdata_i;

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    ack_o  = 1'b0;
    if (READ_LATENCY == 0) begin
      ack_o = accept_o;
    end else if (flush_i) begin
      pend_d = 1'b0;
    end else if (pend_q) begin
      // cnt_q holds how many cycles have elapsed since the accept.
      if (cnt_q == LAT) begin
        ack_o  = 1'b1;
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else if (accept_o) begin
      pend_d = 1'b1;
      cnt_d  = 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID slave (ID then timestamp) on request and reports whether
// both words match the build-time values. Optional watchdog: SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter word_t       EXPECTED_ID    = 32'h0000_0000,
  parameter word_t       EXPECTED_TS    = 32'h5445_CDBA,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  start,
  output logic  avm_address,
  output logic  avm_read,
  input  logic  avm_waitrequest,
  input  word_t avm_readdata,
  output word_t id_value,
  output word_t ts_value,
  output logic  busy,
  output logic  done,
  output logic  match,
  output logic  timeout
);

  state_t state_q, state_d;
  word_t  id_q, id_d;
  word_t  ts_q, ts_d;
  logic   match_q, match_d;
  logic   done_q, done_d;

  logic   rd_req, rd_addr, rd_accept, rd_ack, flush;
  word_t  rd_data;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_expired;

  assign wd_expired = is_read_phase(state_q) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout    = timeout_q;

  // The budget restarts for each of the two reads.
  always_comb begin
    wd_d = wd_q;
    if (is_read_phase(state_q)) wd_d = wd_q + 1'b1;
    if ((state_d inside {RD_ID, RD_TS}) && (state_d != state_q)) wd_d = '0;
  end
`else
  assign flush   = 1'b0;
  assign timeout = 1'b0;
`endif

  avm_single_read #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read (
    .clock            (clock),
    .reset            (reset),
    .req_i            (rd_req),
    .addr_i           (rd_addr),
    .flush_i          (flush),
    .accept_o         (rd_accept),
    .ack_o            (rd_ack),
    .data_o           (rd_data),
    .avm_read_o       (avm_read),
    .avm_address_o    (avm_address),
    .avm_waitrequest_i(avm_waitrequest),
    .avm_readdata_i   (avm_readdata)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ts_d    = ts_q;
    match_d = match_q;
    done_d  = 1'b0;
    rd_req  = 1'b0;
    rd_addr = ADDR_ID;
`ifdef SYSID_CHECKER_TIMEOUT_EN
    flush     = 1'b0;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          match_d = 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      RD_ID: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          id_d    = rd_data;
          state_d = RD_TS;
        end else if (rd_accept) begin
          state_d = LAT_ID;
        end
      end
      LAT_ID: begin
        if (rd_ack) begin
          id_d    = rd_data;
          state_d = RD_TS;
        end
      end
      RD_TS: begin
        rd_req  = 1'b1;
        rd_addr = ADDR_TS;
        if (rd_ack) begin
          ts_d    = rd_data;
          state_d = CHECK;
        end else if (rd_accept) begin
          state_d = LAT_TS;
        end
      end
      LAT_TS: begin
        rd_addr = ADDR_TS;
        if (rd_ack) begin
          ts_d    = rd_data;
          state_d = CHECK;
        end
      end
      CHECK: begin
        match_d = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef SYSID_CHECKER_TIMEOUT_EN
    // Abort wins over a same-cycle capture; earlier captures are kept.
    if (wd_expired) begin
      state_d   = IDLE;
      id_d      = id_q;
      ts_d      = ts_q;
      match_d   = 1'b0;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      flush     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      ts_q    <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      match_q <= match_d;
      done_q  <= done_d;
`ifdef SYSID_CHECKER_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign id_value = id_q;
  assign ts_value = ts_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign match    = match_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: one checker with zero read latency (slave with waitrequest
// control) and one with READ_LATENCY=2 (pipelined slave). Cycle 0 = start cycle.
module tb_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'h5445_CDBA;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] mem_id, mem_ts;

  // Zero-latency instance and its slave.
  logic        start0, rd0, addr0, wr0, busy0, done0, match0, to0;
  logic [31:0] rdata0, id0, ts0;
  int          stall0;
  logic        hold_ts0;

  assign wr0    = (stall0 > 0) || (hold_ts0 && addr0);
  assign rdata0 = (rd0 && !wr0) ? (addr0 ? mem_ts : mem_id) : 32'hBAD0_BAD0;

  sysid_checker #(
    .EXPECTED_ID(32'h0), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0), .TIMEOUT_CYCLES(16)
  ) dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .avm_address(addr0), .avm_read(rd0), .avm_waitrequest(wr0), .avm_readdata(rdata0),
    .id_value(id0), .ts_value(ts0), .busy(busy0), .done(done0), .match(match0), .timeout(to0)
  );

  // Latency-2 instance; slave data valid exactly 2 cycles after accept.
  logic        start2, rd2, addr2, wr2, busy2, done2, match2, to2;
  logic [31:0] rdata2, id2, ts2;
  logic        p1_v, p1_a, p2_v, p2_a;

  assign wr2    = 1'b0;
  assign rdata2 = p2_v ? (p2_a ? mem_ts : mem_id) : 32'hBAD1_BAD1;

  always @(posedge clock) begin
    p1_v <= !reset && rd2 && !wr2;
    p1_a <= addr2;
    p2_v <= !reset && p1_v;
    p2_a <= p1_a;
  end

  sysid_checker #(
    .EXPECTED_ID(32'h0), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2), .TIMEOUT_CYCLES(16)
  ) dut2 (
    .clock(clock), .reset(reset), .start(start2),
    .avm_address(addr2), .avm_read(rd2), .avm_waitrequest(wr2), .avm_readdata(rdata2),
    .id_value(id2), .ts_value(ts2), .busy(busy2), .done(done2), .match(match2), .timeout(to2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle (negedge to negedge); consume one stall cycle if one was spent.
  task automatic step();
    logic pre;
    pre = rd0 && wr0;
    @(negedge clock);
    if (pre && stall0 > 0) stall0--;
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 1) start2 = 1'b1;
    else          start0 = 1'b1;
    step();
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int n0, input int budget, output int n);
    n = n0;
    while (!(sel == 1 ? done2 : done0) && n < budget) begin
      step();
      n++;
    end
  endtask

  int n;
  int seen;

  initial begin
    reset = 1'b1; start0 = 1'b0; start2 = 1'b0;
    stall0 = 0; hold_ts0 = 1'b0;
    mem_id = 32'h0; mem_ts = EXP_TS;
    step(); step();
    reset = 1'b0;

    check("rst_ctl0", {rd0, addr0, busy0, done0, match0, to0}, 0);
    check("rst_id0", id0, 0);
    check("rst_ts0", ts0, 0);
    check("rst_ctl2", {rd2, addr2, busy2, done2, match2, to2}, 0);

    // Matching slave, back-to-back reads.
    pulse_start(0);
    check("bas_c1", {busy0, rd0, addr0, match0}, 4'b1100);
    step();
    check("bas_c2", {rd0, addr0}, 2'b11);
    wait_done(0, 2, 14, n);
    check("bas_lat", n, 4);
    check("bas_match", match0, 1);
    check("bas_id", id0, 0);
    check("bas_ts", ts0, EXP_TS);
    check("bas_busy", busy0, 0);
    repeat (3) step();
    check("bas_hold", {match0, done0}, 2'b10);

    // Start in the done cycle; second start while busy is ignored.
    pulse_start(0);
    wait_done(0, 1, 14, n);
    check("b2b_lat0", n, 4);
    mem_ts = 32'h5445_CDBB;
    pulse_start(0);
    check("b2b_c1", {busy0, match0}, 2'b10);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    wait_done(0, 2, 14, n);
    check("mis_lat", n, 4);
    check("mis_match", match0, 0);
    check("mis_ts", ts0, 32'h5445_CDBB);
    seen = 0;
    repeat (6) begin
      step();
      if (done0 || busy0) seen++;
    end
    check("busy_ignore", seen, 0);

    // ID mismatch.
    mem_ts = EXP_TS;
    mem_id = 32'h0000_0001;
    pulse_start(0);
    wait_done(0, 1, 14, n);
    check("idm_match", match0, 0);
    check("idm_id", id0, 32'h1);
    mem_id = 32'h0;

    // Three waitrequest cycles on the ID read.
    stall0 = 3;
    pulse_start(0);
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("stl_c%0d", c), {rd0, wr0, addr0}, 3'b110);
      if (c < 3) step();
    end
    wait_done(0, 3, 17, n);
    check("stl_lat", n, 7);
    check("stl_match", match0, 1);

    // Reset while in RD_TS.
    hold_ts0 = 1'b1;
    pulse_start(0);
    step();
    check("rts_c2", {rd0, addr0, busy0}, 3'b111);
    reset = 1'b1;
    step();
    check("rts_c3", {rd0, busy0, done0}, 0);
    reset = 1'b0;
    hold_ts0 = 1'b0;
    step();
    check("rts_c4", {done0, busy0}, 0);
    pulse_start(0);
    wait_done(0, 1, 14, n);
    check("rts_lat", n, 4);
    check("rts_match", match0, 1);

`ifdef SYSID_CHECKER_TIMEOUT_EN
    // Waitrequest stuck on the ID read.
    stall0 = 1000;
    pulse_start(0);
    wait_done(0, 1, 30, n);
    check("wd_lat", n, 17);
    check("wd_flags", {to0, match0, rd0, busy0}, 4'b1000);
    check("wd_id", id0, 0);
    stall0 = 0;
    // Stuck on the timestamp read: ID captured, old timestamp kept.
    mem_id = 32'h1234_5678;
    hold_ts0 = 1'b1;
    pulse_start(0);
    check("wd2_c1", {to0, busy0}, 2'b01);
    wait_done(0, 1, 40, n);
    check("wd2_lat", n, 18);
    check("wd2_id", id0, 32'h1234_5678);
    check("wd2_ts", ts0, EXP_TS);
    check("wd2_to", to0, 1);
    hold_ts0 = 1'b0;
    mem_id = 32'h0;
    pulse_start(0);
    wait_done(0, 1, 14, n);
    check("wd3_flags", {match0, to0}, 2'b10);
`else
    // Without the watchdog a stuck slave holds the FSM in RD_ID.
    stall0 = 1000;
    pulse_start(0);
    seen = 0;
    repeat (40) begin
      step();
      if (done0) seen++;
    end
    check("stk_flags", {busy0, rd0, addr0, to0}, 4'b1100);
    check("stk_done", seen, 0);
    stall0 = 0;
    wait_done(0, 41, 60, n);
    check("stk_lat", n, 44);
    check("stk_match", match0, 1);
`endif

    // READ_LATENCY=2 instance.
    pulse_start(1);
    check("l2_c1", {rd2, addr2}, 2'b10);
    step();
    check("l2_c2", rd2, 0);
    step();
    check("l2_c3", rd2, 0);
    step();
    check("l2_c4", {rd2, addr2}, 2'b11);
    wait_done(1, 4, 20, n);
    check("l2_lat", n, 8);
    check("l2_match", match2, 1);
    check("l2_id", id2, 0);
    check("l2_ts", ts2, EXP_TS);
    mem_id = 32'hFFFF_FFFF;
    pulse_start(1);
    wait_done(1, 1, 20, n);
    check("l2m_lat", n, 8);
    check("l2m_match", match2, 0);
    check("l2m_id", id2, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
